// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter measurement stage.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        COUNT,
        LATCH,
        CLEAR
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Width of a counter that must hold values 0 .. cycles-1 (at least 1 bit).
    function automatic int gate_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit decimal ripple counter that saturates at all-9s and flags overflow.
module bcd_counter
    import freq_meter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc,
    output logic [4*DIGITS-1:0] count,
    output logic                ovf
);

    logic [4*DIGITS-1:0] count_inc;
    logic                all_max;
    logic                carry;
    bcd_digit_t          digit;

    // Carry ripples upward through digits that are already at 9.
    always_comb begin
        count_inc = count;
        all_max   = 1'b1;
        carry     = 1'b1;
        digit     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (digit != BCD_MAX_DIGIT) begin
                all_max = 1'b0;
            end
            if (carry) begin
                if (digit == BCD_MAX_DIGIT) begin
                    count_inc[4*i +: 4] = '0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (all_max) begin
                ovf <= 1'b1;
            end else begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter with BCD result latch and hysteretic auto-ranging of the
// upstream prescaler; windows following any range change are discarded.
module freq_gate_counter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES     = 50_000_000,
    parameter int DIGITS          = 4,
    parameter int LOW_DIGIT_LIMIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal_in,
    input  logic                auto_en,
    input  logic                manual_range,
    output logic                range,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow,
    output logic                range_used,
    output logic                result_valid
);

    localparam int              GW        = gate_width(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam bcd_digit_t      LOW_DIGIT = bcd_digit_t'(LOW_DIGIT_LIMIT);

    state_t              state;
    state_t              state_next;
    logic                sync_ff1;
    logic                sync_ff2;
    logic                edge_reg;
    logic                edge_pulse;
    logic [GW-1:0]       gate_cnt;
    logic [4*DIGITS-1:0] count;
    logic                ovf;
    logic                settle;
    logic                next_range;
    logic                next_range_q;
    bcd_digit_t          top_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_ff1 <= signal_in;
            sync_ff2 <= sync_ff1;
            edge_reg <= sync_ff2;
        end
    end

    assign edge_pulse = sync_ff2 & ~edge_reg;
    assign top_digit  = count[4*DIGITS-1 -: 4];

    bcd_counter #(
        .DIGITS(DIGITS)
    ) u_bcd_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(state == CLEAR),
        .inc  (edge_pulse && (state == COUNT)),
        .count(count),
        .ovf  (ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            COUNT:   if (gate_cnt == GATE_LAST) state_next = LATCH;
            LATCH:   state_next = CLEAR;
            CLEAR:   state_next = COUNT;
            default: state_next = COUNT;
        endcase
    end

    // Step up on overflow, step down only when the top digit is nearly empty.
    always_comb begin
        next_range = range;
        if (!auto_en) begin
            next_range = manual_range;
        end else if (!range && ovf) begin
            next_range = 1'b1;
        end else if (range && !ovf && (top_digit < LOW_DIGIT)) begin
            next_range = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt     <= '0;
            range        <= 1'b0;
            next_range_q <= 1'b0;
            settle       <= 1'b1;
            bcd_out      <= '0;
            overflow     <= 1'b0;
            range_used   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                COUNT: begin
                    gate_cnt <= (gate_cnt == GATE_LAST) ? '0 : gate_cnt + 1'b1;
                end
                LATCH: begin
                    next_range_q <= next_range;
                    if (settle) begin
                        settle <= 1'b0;
                    end else begin
                        bcd_out      <= count;
                        overflow     <= ovf;
                        range_used   <= range;
                        result_valid <= 1'b1;
                    end
                end
                CLEAR: begin
                    gate_cnt <= '0;
                    range    <= next_range_q;
                    if (next_range_q != range) begin
                        settle <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter with a behavioural divide-by-10 prescaler model.
module tb_freq_gate_counter;

    localparam int G      = 600;
    localparam int DIGITS = 2;
    localparam int WIN    = G + 2;

    typedef struct packed {
        logic [4*DIGITS-1:0] bcd;
        logic                ovf;
        logic                ru;
    } result_t;

    result_t exp_q[$];

    logic                clk = 1'b0;
    logic                rst;
    logic                signal_in;
    logic                auto_en;
    logic                manual_range;
    logic                range;
    logic [4*DIGITS-1:0] bcd_out;
    logic                overflow;
    logic                range_used;
    logic                result_valid;

    int   tests_run    = 0;
    int   tests_failed = 0;

    int   gen_period   = 0;
    int   phase        = 0;
    logic gen_raw      = 1'b0;
    logic manual_level = 1'b0;
    logic raw;
    int   div_cnt      = 0;
    logic div_out;

    freq_gate_counter #(
        .GATE_CYCLES    (G),
        .DIGITS         (DIGITS),
        .LOW_DIGIT_LIMIT(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signal_in   (signal_in),
        .auto_en     (auto_en),
        .manual_range(manual_range),
        .range       (range),
        .bcd_out     (bcd_out),
        .overflow    (overflow),
        .range_used  (range_used),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Raw input: 50% duty square wave of gen_period clocks, or a manually driven level.
    always @(negedge clk) begin
        if (gen_period == 0) begin
            phase   <= 0;
            gen_raw <= 1'b0;
        end else begin
            phase   <= (phase >= gen_period - 1) ? 0 : phase + 1;
            gen_raw <= (phase < gen_period / 2);
        end
    end

    assign raw = (gen_period == 0) ? manual_level : gen_raw;

    always @(posedge raw) div_cnt <= (div_cnt == 9) ? 0 : div_cnt + 1;

    assign div_out   = (div_cnt < 5);
    assign signal_in = range ? div_out : raw;

    task automatic do_reset(input int period, input logic auto, input logic man);
        rst          = 1'b1;
        gen_period   = period;
        auto_en      = auto;
        manual_range = man;
        manual_level = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_result(input int budget, output bit got, output int waited);
        got    = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            if (result_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_basic();
        bit      got;
        int      waited;
        int      early;
        result_t e;
        do_reset(10, 1'b0, 1'b0);
        early = 0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_settle: %0d result_valid pulses in settle window, required 0", early);
        end
        exp_q.push_back('{bcd: 8'h60, ovf: 1'b0, ru: 1'b0});
        exp_q.push_back('{bcd: 8'h60, ovf: 1'b0, ru: 1'b0});
        for (int n = 0; n < 2; n++) begin
            wait_result(WIN + 10, got, waited);
            e = exp_q.pop_front();
            tests_run++;
            if (!got) begin
                tests_failed++;
                $display("[TB] FAIL basic_valid%0d: result_valid=0 after %0d cycles, required 1", n, waited);
            end
            tests_run++;
            if ({bcd_out, overflow, range_used} !== e) begin
                tests_failed++;
                $display("[TB] FAIL basic_result%0d: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                         n, bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
            end
            if (n == 1) begin
                tests_run++;
                if (waited !== WIN - 1) begin
                    tests_failed++;
                    $display("[TB] FAIL basic_period: result spacing %0d, required %0d", waited + 1, WIN);
                end
            end
            @(negedge clk);
            tests_run++;
            if (result_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL basic_pulse%0d: result_valid=%b one cycle later, required 0", n, result_valid);
            end
        end
        tests_run++;
        if (range !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_range: range=%b, required 0", range);
        end
    endtask

    task automatic test_manual_overflow();
        bit      got;
        int      waited;
        result_t e;
        do_reset(4, 1'b0, 1'b0);
        exp_q.push_back('{bcd: 8'h99, ovf: 1'b1, ru: 1'b0});
        wait_result(2 * WIN + 10, got, waited);
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL ovf_valid: result_valid=0 after %0d cycles, required 1", waited);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used} !== e) begin
            tests_failed++;
            $display("[TB] FAIL ovf_result: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                     bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (range !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_range: range=%b in manual mode, required 0", range);
        end
    endtask

    task automatic test_auto_up();
        bit      got;
        int      waited;
        result_t e;
        auto_en = 1'b1;
        exp_q.push_back('{bcd: 8'h99, ovf: 1'b1, ru: 1'b0});
        exp_q.push_back('{bcd: 8'h15, ovf: 1'b0, ru: 1'b1});
        wait_result(WIN + 10, got, waited);
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL up_valid0: result_valid=0 after %0d cycles, required 1", waited);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used} !== e) begin
            tests_failed++;
            $display("[TB] FAIL up_result0: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                     bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (range !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL up_range: range=%b after overflow window, required 1", range);
        end
        wait_result(2 * WIN + 10, got, waited);
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL up_valid1: result_valid=0 after %0d cycles, required 1", waited);
        end
        tests_run++;
        if (waited !== 2 * WIN - 2) begin
            tests_failed++;
            $display("[TB] FAIL up_discard: next result after %0d cycles, required %0d", waited, 2 * WIN - 2);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used} !== e) begin
            tests_failed++;
            $display("[TB] FAIL up_result1: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                     bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
        end
    endtask

    task automatic test_reset();
        bit      got;
        int      waited;
        result_t e;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (range !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_range: range=%b during reset, required 0", range);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used, result_valid} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got bcd=%h ovf=%b ru=%b rv=%b, required all 0",
                     bcd_out, overflow, range_used, result_valid);
        end
        auto_en      = 1'b0;
        manual_range = 1'b0;
        gen_period   = 10;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{bcd: 8'h60, ovf: 1'b0, ru: 1'b0});
        wait_result(2 * WIN + 10, got, waited);
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: result_valid=0 after %0d cycles, required 1", waited);
        end
        tests_run++;
        if (waited !== 2 * G + 3) begin
            tests_failed++;
            $display("[TB] FAIL reset_first: first result after %0d cycles, required %0d", waited, 2 * G + 3);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used} !== e) begin
            tests_failed++;
            $display("[TB] FAIL reset_result: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                     bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
        end
    endtask

    task automatic test_auto_down();
        bit      got;
        bit      seen;
        int      waited;
        result_t e;
        do_reset(10, 1'b0, 1'b1);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < WIN + 10) begin
            @(negedge clk);
            waited++;
            if (range === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL down_manual: range=%b after %0d cycles, required 1", range, waited);
        end
        auto_en = 1'b1;
        exp_q.push_back('{bcd: 8'h60, ovf: 1'b0, ru: 1'b0});
        wait_result(3 * WIN + 10, got, waited);
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("[TB] FAIL down_valid: result_valid=0 after %0d cycles, required 1", waited);
        end
        tests_run++;
        if (waited !== 3 * WIN - 1) begin
            tests_failed++;
            $display("[TB] FAIL down_timing: result after %0d cycles, required %0d", waited, 3 * WIN - 1);
        end
        tests_run++;
        if ({bcd_out, overflow, range_used} !== e) begin
            tests_failed++;
            $display("[TB] FAIL down_result: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                     bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
        end
        tests_run++;
        if (range !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL down_range: range=%b, required 0", range);
        end
    endtask

    task automatic test_last_cycle();
        bit      got;
        int      waited;
        result_t e;
        do_reset(0, 1'b0, 1'b0);
        exp_q.push_back('{bcd: 8'h00, ovf: 1'b0, ru: 1'b0});
        wait_result(2 * WIN + 10, got, waited);
        for (int n = 0; n < 4; n++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (!got) begin
                tests_failed++;
                $display("[TB] FAIL edge_valid%0d: result_valid=0 after %0d cycles, required 1", n, waited);
            end
            tests_run++;
            if ({bcd_out, overflow, range_used} !== e) begin
                tests_failed++;
                $display("[TB] FAIL edge_result%0d: got bcd=%h ovf=%b ru=%b, required bcd=%h ovf=%b ru=%b",
                         n, bcd_out, overflow, range_used, e.bcd, e.ovf, e.ru);
            end
            if (n == 0) begin
                // Edge lands on the final counting cycle and must be counted.
                repeat (G - 2) @(negedge clk);
                manual_level = 1'b1;
                exp_q.push_back('{bcd: 8'h01, ovf: 1'b0, ru: 1'b0});
            end else if (n == 1) begin
                // Edge lands in the latch cycle and must vanish.
                repeat (G - 1) @(negedge clk);
                manual_level = 1'b1;
                exp_q.push_back('{bcd: 8'h00, ovf: 1'b0, ru: 1'b0});
            end else begin
                exp_q.push_back('{bcd: 8'h00, ovf: 1'b0, ru: 1'b0});
            end
            if (n < 3) begin
                wait_result(WIN + 10, got, waited);
                manual_level = 1'b0;
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst          = 1'b1;
        auto_en      = 1'b0;
        manual_range = 1'b0;
        test_basic();
        test_manual_overflow();
        test_auto_up();
        test_reset();
        test_auto_down();
        test_last_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
